// File: rtl/hazard_ctrl.sv
// Hazard control: forwarding selects, load-use and mul/div stalls, branch flush.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_wr,
  input  logic       id_ld,
  input  logic       id_md,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       br_taken,
  output logic       stall,
  output logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [3:0] LAST = 4'(MD_LAT - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_wr, ex_ld, ex_md;
  logic [4:0] mem_rd, wb_rd;
  logic       mem_wr, wb_wr;

  logic md_hold, flush_i, lu, stall_i, advance, md_enter;
  logic [1:0] fa, fb;

  // Hazard detection and forwarding selection
  always_comb begin
    md_hold  = (state == MD_BUSY) && (cnt < LAST);
    flush_i  = br_taken && (state == RUN);
    lu       = ex_ld && ex_wr && (ex_rd != 5'd0) && id_valid &&
               ((id_rs_used && id_rs == ex_rd) ||
                (id_rt_used && id_rt == ex_rd));
    stall_i  = md_hold || (lu && !flush_i);
    advance  = !stall_i && !flush_i;
    md_enter = advance && id_valid && id_md;
    fa = 2'b00;
    if (mem_wr && mem_rd != 5'd0 && mem_rd == ex_rs) fa = 2'b10;
    else if (wb_wr && wb_rd != 5'd0 && wb_rd == ex_rs) fa = 2'b01;
    fb = 2'b00;
    if (mem_wr && mem_rd != 5'd0 && mem_rd == ex_rt) fb = 2'b10;
    else if (wb_wr && wb_rd != 5'd0 && wb_rd == ex_rt) fb = 2'b01;
  end

  assign stall     = stall_i && !rst;
  assign flush     = flush_i && !rst;
  assign fwd_a_sel = rst ? 2'b00 : fa;
  assign fwd_b_sel = rst ? 2'b00 : fb;

  // Mul/div occupancy FSM next-state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (md_enter) begin
          state_nx = MD_BUSY;
          cnt_nx   = 4'd0;
        end
      end
      MD_BUSY: begin
        if (md_hold) begin
          cnt_nx = cnt + 4'd1;
        end else if (md_enter) begin
          cnt_nx = 4'd0;
        end else begin
          state_nx = RUN;
          cnt_nx   = 4'd0;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Shadow pipeline: EX holds during mul/div, else loads ID or a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs  <= 5'd0;
      ex_rt  <= 5'd0;
      ex_rd  <= 5'd0;
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_md  <= 1'b0;
      mem_rd <= 5'd0;
      mem_wr <= 1'b0;
      wb_rd  <= 5'd0;
      wb_wr  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
      mem_rd <= ex_rd;
      mem_wr <= md_hold ? 1'b0 : ex_wr;
      if (!md_hold) begin
        if (advance && id_valid) begin
          ex_rs <= id_rs;
          ex_rt <= id_rt;
          ex_rd <= id_rd;
          ex_wr <= id_wr;
          ex_ld <= id_ld;
          ex_md <= id_md;
        end else begin
          ex_rs <= 5'd0;
          ex_rt <= 5'd0;
          ex_rd <= 5'd0;
          ex_wr <= 1'b0;
          ex_ld <= 1'b0;
          ex_md <= 1'b0;
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] scnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) scnt <= 16'd0;
    else if (stall && scnt != 16'hFFFF) scnt <= scnt + 16'd1;
  end

  assign stall_cnt = scnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed table plus randomized stimulus
// checked against an instruction-level pipeline model.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;

  typedef struct {
    logic       wr, ld, md;
    logic [4:0] rs, rt, rd;
    logic       rsu, rtu;
  } ins_t;

  typedef struct {
    logic       rst, idv, br;
    ins_t       id;
    logic       tab;
    logic       e_stall, e_flush;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  logic clk = 1'b0;
  logic rst, id_valid, id_wr, id_ld, id_md, id_rs_used, id_rt_used, br_taken;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  ins_t m_ex, m_mem, m_wb;
  int   m_age;
  int   m_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_wr(id_wr), .id_ld(id_ld), .id_md(id_md),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .br_taken(br_taken),
    .stall(stall), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt)
  );

  function automatic ins_t mk(input logic wr, ld, md,
                              input int rs, rt, rd,
                              input logic rsu, rtu);
    ins_t i;
    i.wr = wr; i.ld = ld; i.md = md;
    i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    i.rsu = rsu; i.rtu = rtu;
    return i;
  endfunction

  function automatic ins_t bub();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] r);
    if (m_mem.wr && m_mem.rd != 0 && m_mem.rd == r) return 2'b10;
    if (m_wb.wr && m_wb.rd != 0 && m_wb.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v);
    logic hold, fl, lu, st;
    logic [1:0] fa, fb;
    rst = v.rst; id_valid = v.idv; br_taken = v.br;
    id_wr = v.id.wr; id_ld = v.id.ld; id_md = v.id.md;
    id_rs = v.id.rs; id_rt = v.id.rt; id_rd = v.id.rd;
    id_rs_used = v.id.rsu; id_rt_used = v.id.rtu;
    hold = m_ex.md && (m_age < MD_LAT - 1);
    fl = v.br && !m_ex.md;
    lu = m_ex.ld && m_ex.wr && m_ex.rd != 0 && v.idv &&
         ((v.id.rsu && v.id.rs == m_ex.rd) ||
          (v.id.rtu && v.id.rt == m_ex.rd));
    st = hold || (lu && !fl);
    fa = v.rst ? 2'b00 : fsel(m_ex.rs);
    fb = v.rst ? 2'b00 : fsel(m_ex.rt);
    @(negedge clk);
    chk("model_stall", 16'(stall), 16'(st && !v.rst));
    chk("model_flush", 16'(flush), 16'(fl && !v.rst));
    chk("model_fwd_a", 16'(fwd_a_sel), 16'(fa));
    chk("model_fwd_b", 16'(fwd_b_sel), 16'(fb));
    if (!v.rst) chk("model_stall_cnt", stall_cnt, 16'(m_cnt));
    if (v.tab) begin
      chk("tab_stall", 16'(stall), 16'(v.e_stall));
      chk("tab_flush", 16'(flush), 16'(v.e_flush));
      chk("tab_fwd_a", 16'(fwd_a_sel), 16'(v.e_fa));
      chk("tab_fwd_b", 16'(fwd_b_sel), 16'(v.e_fb));
    end
    if (v.rst) begin
      m_ex = bub(); m_mem = bub(); m_wb = bub();
      m_age = 0; m_cnt = 0;
    end else begin
`ifdef HAZARD_STATS_EN
      if (st && m_cnt < 65535) m_cnt++;
`endif
      m_wb = m_mem;
      if (hold) begin
        m_mem = bub();
        m_age++;
      end else begin
        m_mem = m_ex;
        m_ex = (fl || lu || !v.idv) ? bub() : v.id;
        m_age = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t row(input logic r, idv, br, input ins_t id,
                               input logic s, f, input int a, b);
    vec_t v;
    v.rst = r; v.idv = idv; v.br = br; v.id = id; v.tab = 1'b1;
    v.e_stall = s; v.e_flush = f; v.e_fa = 2'(a); v.e_fb = 2'(b);
    return v;
  endfunction

  vec_t tab[27];

  initial begin
    ins_t nop, mul_i, rnd;
    vec_t v;
    int post;
    nop = bub();
    mul_i = mk(1, 0, 1, 1, 2, 9, 1, 1);
    m_ex = bub(); m_mem = bub(); m_wb = bub();
    m_age = 0; m_cnt = 0;
    rst = 1; id_valid = 0; id_wr = 0; id_ld = 0; id_md = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rs_used = 0; id_rt_used = 0;
    br_taken = 0;

    tab[0]  = row(1, 0, 0, nop, 0, 0, 0, 0);
    tab[1]  = row(0, 1, 0, mk(1, 0, 0, 1, 2, 3, 1, 1), 0, 0, 0, 0);
    tab[2]  = row(0, 1, 0, mk(1, 0, 0, 3, 0, 4, 1, 1), 0, 0, 0, 0);
    tab[3]  = row(0, 1, 0, mk(1, 0, 0, 3, 2, 6, 1, 1), 0, 0, 2, 0);
    tab[4]  = row(0, 0, 0, nop, 0, 0, 1, 0);
    tab[5]  = row(0, 1, 0, mk(1, 1, 0, 1, 0, 5, 1, 0), 0, 0, 0, 0);
    tab[6]  = row(0, 1, 0, mk(1, 0, 0, 1, 5, 7, 1, 1), 1, 0, 0, 0);
    tab[7]  = row(0, 1, 0, mk(1, 0, 0, 1, 5, 7, 1, 1), 0, 0, 0, 0);
    tab[8]  = row(0, 0, 0, nop, 0, 0, 0, 1);
    tab[9]  = row(0, 1, 0, mk(1, 0, 0, 1, 0, 0, 1, 0), 0, 0, 0, 0);
    tab[10] = row(0, 1, 0, mk(1, 0, 0, 0, 0, 8, 1, 1), 0, 0, 0, 0);
    tab[11] = row(0, 1, 0, mul_i, 0, 0, 0, 0);
    tab[12] = row(0, 1, 0, mk(1, 0, 0, 9, 0, 10, 1, 0), 1, 0, 0, 0);
    tab[13] = row(0, 1, 1, mk(1, 0, 0, 9, 0, 10, 1, 0), 1, 0, 0, 0);
    tab[14] = row(0, 1, 0, mk(1, 0, 0, 9, 0, 10, 1, 0), 1, 0, 0, 0);
    tab[15] = row(0, 1, 0, mk(1, 0, 0, 9, 0, 10, 1, 0), 0, 0, 0, 0);
    tab[16] = row(0, 0, 1, nop, 0, 1, 2, 0);
    tab[17] = row(0, 1, 0, mk(1, 0, 1, 1, 2, 11, 1, 1), 0, 0, 0, 0);
    tab[18] = row(0, 0, 0, nop, 1, 0, 0, 0);
    tab[19] = row(1, 0, 0, nop, 0, 0, 0, 0);
    tab[20] = row(0, 0, 0, nop, 0, 0, 0, 0);
    tab[21] = row(0, 1, 0, mk(1, 1, 0, 1, 0, 12, 1, 0), 0, 0, 0, 0);
    tab[22] = row(0, 1, 1, mk(1, 0, 0, 12, 0, 13, 1, 0), 0, 1, 0, 0);
    tab[23] = row(0, 1, 0, mk(1, 0, 0, 12, 0, 13, 1, 0), 0, 0, 0, 0);
    tab[24] = row(0, 1, 0, mk(1, 1, 0, 1, 0, 0, 1, 0), 0, 0, 1, 0);
    tab[25] = row(0, 1, 0, mk(1, 0, 0, 0, 0, 14, 1, 1), 0, 0, 0, 0);
    tab[26] = row(0, 0, 0, nop, 0, 0, 0, 0);

    #1;
    for (int i = 0; i < 27; i++) begin
      step(tab[i]);
      if (i == 20) chk("cnt_after_rst", stall_cnt, 16'h0000);
    end

    for (int i = 0; i < 1500; i++) begin
      logic kind;
      rnd = mk(1'($urandom_range(0, 1)), 0, 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      kind = ($urandom_range(0, 11) == 0);
      if (kind) rnd.md = 1'b1;
      else if ($urandom_range(0, 4) == 0) begin
        rnd.ld = 1'b1; rnd.wr = 1'b1;
      end
      v.rst = ($urandom_range(0, 99) == 0);
      v.idv = ($urandom_range(0, 5) != 0);
      v.br  = ($urandom_range(0, 7) == 0);
      v.id  = rnd;
      v.tab = 1'b0;
      v.e_stall = 0; v.e_flush = 0; v.e_fa = 0; v.e_fb = 0;
      step(v);
    end

    v = row(1, 0, 0, nop, 0, 0, 0, 0);
    v.tab = 1'b0;
    step(v);
    v = row(0, 1, 0, mul_i, 0, 0, 0, 0);
    v.tab = 1'b0;
`ifdef HAZARD_STATS_EN
    post = 0;
    for (int i = 0; i < 90000 && post < 8; i++) begin
      step(v);
      if (m_cnt == 65535) post++;
    end
    chk("cnt_saturated", stall_cnt, 16'hFFFF);
`else
    post = 0;
    for (int i = 0; i < 40; i++) begin
      step(v);
      post++;
    end
    chk("cnt_tied_zero", stall_cnt, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MD_LAT, default 4, mul/div EX occupancy in cycles (legal 2..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_valid, id_wr, id_ld, id_md  input  1 each  ID instr valid / writes reg / is load / is mul-div.
REQ-005 id_rs, id_rt, id_rd  input  5 each  ID source and destination register numbers.
REQ-006 id_rs_used, id_rt_used  input  1 each  ID instr reads rs / rt.
REQ-007 br_taken  input  1  branch in EX resolved taken this cycle.
REQ-008 stall  output  1  hold PC and IF/ID; insert or hold EX per REQ-015/016.
REQ-009 flush  output  1  squash IF/ID and ID contents this cycle.
REQ-010 fwd_a_sel, fwd_b_sel  output  2 each  EX operand A/B mux select: 00 regfile, 01 WB result, 10 MEM result; 11 never driven.
REQ-011 stall_cnt  output  16  stall-cycle count (REQ-026).

Function
REQ-012 Internal shadow pipeline: EX {rs, rt, rd, wr, ld, md, rs_used, rt_used}, MEM {rd, wr}, WB {rd, wr}; MEM<=EX and WB<=MEM every cycle, except MEM receives a bubble (wr=0) while EX holds (REQ-016).
REQ-013 fwd_a_sel combinational from shadow regs: 10 if MEM.wr, MEM.rd!=0 and MEM.rd==EX.rs; else 01 if WB.wr, WB.rd!=0 and WB.rd==EX.rs; else 00; fwd_b_sel identical using EX.rt.
REQ-014 MEM match has priority over WB match; destination r0 never forwards.
REQ-015 Load-use: stall=1 when EX.ld, EX.wr, EX.rd!=0, id_valid and ((id_rs_used and id_rs==EX.rd) or (id_rt_used and id_rt==EX.rd)); next cycle EX loads a bubble (all flags 0); exactly one stall cycle per load-use.
REQ-016 FSM states RUN, MD_BUSY; RUN->MD_BUSY on the edge an md instr enters EX; 4-bit counter cleared on entry, incremented each MD_BUSY cycle; stall=1 and EX held while in MD_BUSY and counter < MD_LAT-1; MD_BUSY->RUN when counter == MD_LAT-1 (EX advances on that edge).
REQ-017 MD instr therefore occupies EX exactly MD_LAT cycles with stall high MD_LAT-1 cycles; back-to-back md instrs re-enter MD_BUSY with counter cleared.
REQ-018 Normal advance (stall=0, flush=0): EX <= ID fields gated by id_valid (invalid -> bubble).
REQ-019 br_taken in RUN: flush=1 same cycle, stall forced 0, EX loads bubble next cycle; flush overrides load-use.
REQ-020 br_taken in MD_BUSY is ignored (flush=0).
REQ-021 stall and flush are combinational from shadow regs, FSM state and ID/br inputs; zero-cycle latency.

Reset
REQ-022 rst=1 at an edge: all shadow valid/wr/ld/md flags 0, FSM RUN, counter 0, stall_cnt 0.
REQ-023 Outputs during and right after reset: stall=0, flush=0, fwd_a_sel=fwd_b_sel=00.
REQ-024 rst mid-MD_BUSY aborts the sequence; state RUN next cycle, no residual stall.
REQ-025 rst has priority over every other event in the same cycle.

Configuration
REQ-026 Macro HAZARD_STATS_EN defined: stall_cnt increments by 1 on each clk edge where stall=1, saturates at 16'hFFFF, clears only on rst.
REQ-027 HAZARD_STATS_EN undefined: counter logic absent, stall_cnt tied to 16'h0000; all other behaviour identical.

Verification
REQ-028 add r3 enters EX, next ID reads r3 as rs -> cycle consumer in EX: fwd_a_sel=10; following consumer of r3: fwd_a_sel=01.
REQ-029 lw r5 in EX, ID reads r5 as rt (rt_used=1) -> stall=1 one cycle, bubble in EX, then consumer in EX with fwd_b_sel=01.
REQ-030 Instr writing r0 followed by reader of r0 -> fwd_a_sel=fwd_b_sel=00, stall=0.
REQ-031 MD_LAT=4, mult enters EX -> stall=1 for 3 consecutive cycles, EX held 4 cycles, br_taken pulsed mid-busy -> flush stays 0.
REQ-032 rst asserted during 2nd MD_BUSY cycle -> next cycle stall=0, fwd selects 00, stall_cnt=0.
REQ-033 HAZARD_STATS_EN on, stall forced 70000 cycles -> stall_cnt holds 16'hFFFF; macro off -> stall_cnt=0 throughout.
